// File: rtl/regfile_mp.sv
// Multi-port integer register file with RAW scoreboard for the decode stage.
// Reads are combinational or registered, and both modes bypass same-cycle writeback data.
module regfile_mp #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned AW     = 5,
   parameter int unsigned NRD    = 2,
   parameter int unsigned NWR    = 2,
   parameter int unsigned RD_REG = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   waddr,
   input  logic [NWR*XLEN-1:0] wdata,
   input  logic [NRD-1:0]      re,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rvalid,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic [NREG-1:0]     busy
);

   logic [XLEN-1:0]     r_regs [NREG];
   logic [NREG-1:0]     r_busy;
   logic [NREG-1:0]     w_busy_nxt;
   logic [NRD*XLEN-1:0] w_rdata;
   logic [NRD-1:0]      w_rvalid;

   // Register array: later ports overwrite earlier ones, so the highest index wins
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < int'(NREG); k++) r_regs[k] <= '0;
      end else begin
         for (int i = 0; i < int'(NWR); i++) begin
            if (we[i] && (waddr[i*AW +: AW] != '0))
               r_regs[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
         end
      end
   end

   // Writeback clears, issue sets afterwards so a newer producer keeps the bit
   always_comb begin
      w_busy_nxt = r_busy;
      for (int i = 0; i < int'(NWR); i++) begin
         if (we[i]) w_busy_nxt[waddr[i*AW +: AW]] = 1'b0;
      end
      if (iss_en) w_busy_nxt[iss_addr] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) r_busy <= '0;
      else      r_busy <= w_busy_nxt;
   end

   assign busy = r_busy;

   // Operand lookup: x0, then writeback bypass, then array with scoreboard ready
   always_comb begin
      w_rdata  = '0;
      w_rvalid = '0;
      for (int j = 0; j < int'(NRD); j++) begin
         if (re[j]) begin
            if (raddr[j*AW +: AW] == '0) begin
               w_rvalid[j] = 1'b1;
            end else begin
               w_rdata[j*XLEN +: XLEN] = r_regs[raddr[j*AW +: AW]];
               w_rvalid[j]             = ~r_busy[raddr[j*AW +: AW]];
               for (int i = 0; i < int'(NWR); i++) begin
                  if (we[i] && (waddr[i*AW +: AW] == raddr[j*AW +: AW])) begin
                     w_rdata[j*XLEN +: XLEN] = wdata[i*XLEN +: XLEN];
                     w_rvalid[j]             = 1'b1;
                  end
               end
            end
         end
      end
   end

   if (RD_REG != 0) begin : g_rd_reg
      logic [NRD*XLEN-1:0] r_rdata;
      logic [NRD-1:0]      r_rvalid;

      always_ff @(posedge clk) begin
         if (!rst) begin
            r_rdata  <= '0;
            r_rvalid <= '0;
         end else if (!stall) begin
            r_rdata  <= w_rdata;
            r_rvalid <= w_rvalid;
         end
      end

      assign rdata  = r_rdata;
      assign rvalid = r_rvalid;
   end else begin : g_rd_comb
      logic w_unused_stall;
      assign w_unused_stall = stall;
      assign rdata  = rst ? w_rdata  : '0;
      assign rvalid = rst ? w_rvalid : '0;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: combinational and registered-read instances share one stimulus stream
// and are compared against an array-based model of the register file and scoreboard.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic        stall;
   logic [1:0]  we;
   logic [9:0]  waddr;
   logic [63:0] wdata;
   logic [1:0]  re;
   logic [9:0]  raddr;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic [63:0] c_rdata, q_rdata;
   logic [1:0]  c_rvalid, q_rvalid;
   logic [31:0] c_busy, q_busy;

   regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .NWR(2), .RD_REG(0)) u_comb (
      .clk(clk), .rst(rst), .stall(stall), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(c_rdata), .rvalid(c_rvalid),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy(c_busy));

   regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .NWR(2), .RD_REG(1)) u_reg (
      .clk(clk), .rst(rst), .stall(stall), .we(we), .waddr(waddr), .wdata(wdata),
      .re(re), .raddr(raddr), .rdata(q_rdata), .rvalid(q_rvalid),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy(q_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          chk_en   = 1'b0;
   logic [31:0] m_regs [32];
   logic [31:0] m_busy;
   logic [31:0] m_qd [2];
   logic        m_qv [2];

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [1:0]  re;
      logic [4:0]  ra0, ra1;
      logic        iss;
      logic [4:0]  ia;
      logic [31:0] ed0;
      logic        ev0;
      logic [31:0] ed1;
      logic        ev1;
      logic [31:0] ebusy;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Operand read from the architectural state held in the model arrays
   function automatic void model_f(input int j, output logic [31:0] d, output logic v);
      logic [4:0] a;
      a = raddr[j*5 +: 5];
      d = 32'h0;
      v = 1'b0;
      if (re[j]) begin
         if (a == 5'd0) begin
            v = 1'b1;
         end else begin
            d = m_regs[a];
            v = ~m_busy[a];
            for (int i = 0; i < 2; i++) begin
               if (we[i] && waddr[i*5 +: 5] == a) begin
                  d = wdata[i*32 +: 32];
                  v = 1'b1;
               end
            end
         end
      end
   endfunction

   task automatic idle();
      rst = 1'b1; stall = 1'b0; we = 2'b00; waddr = '0; wdata = '0;
      re = 2'b00; raddr = '0; iss_en = 1'b0; iss_addr = '0;
   endtask

   // Check both DUTs against the model, then advance the model and the clock by one edge
   task automatic tick();
      logic [31:0] d;
      logic        v;
      #1;
      if (chk_en) begin
         for (int j = 0; j < 2; j++) begin
            model_f(j, d, v);
            if (!rst) begin d = 32'h0; v = 1'b0; end
            chk($sformatf("comb_rdata%0d", j), 64'(c_rdata[j*32 +: 32]), 64'(d));
            chk($sformatf("comb_rvalid%0d", j), 64'(c_rvalid[j]), 64'(v));
            chk($sformatf("reg_rdata%0d", j), 64'(q_rdata[j*32 +: 32]), 64'(m_qd[j]));
            chk($sformatf("reg_rvalid%0d", j), 64'(q_rvalid[j]), 64'(m_qv[j]));
         end
         chk("busy_comb", 64'(c_busy), 64'(m_busy));
         chk("busy_reg", 64'(q_busy), 64'(m_busy));
      end
      if (!rst) begin
         for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
         m_busy = 32'h0;
         for (int j = 0; j < 2; j++) begin m_qd[j] = 32'h0; m_qv[j] = 1'b0; end
      end else begin
         if (!stall) begin
            for (int j = 0; j < 2; j++) begin
               model_f(j, d, v);
               m_qd[j] = d;
               m_qv[j] = v;
            end
         end
         for (int i = 0; i < 2; i++)
            if (we[i] && waddr[i*5 +: 5] != 5'd0) m_regs[waddr[i*5 +: 5]] = wdata[i*32 +: 32];
         for (int i = 0; i < 2; i++)
            if (we[i]) m_busy[waddr[i*5 +: 5]] = 1'b0;
         if (iss_en && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      m_busy = 32'h0;
      for (int j = 0; j < 2; j++) begin m_qd[j] = 32'h0; m_qv[j] = 1'b0; end

      //            we     wa0    wa1    wd0           wd1        re     ra0    ra1    iss   ia     ed0           ev0   ed1       ev1   ebusy
      tbl[0]  = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,     2'b11, 5'd5,  5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 1'b1, 32'h0,    1'b1, 32'h0};
      tbl[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,     2'b01, 5'd5,  5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 1'b1, 32'h0,    1'b0, 32'h0};
      tbl[2]  = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22,    2'b10, 5'd0,  5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 32'h22,   1'b1, 32'h0};
      tbl[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,     2'b11, 5'd7,  5'd5,  1'b0, 5'd0,  32'h22,       1'b1, 32'hDEADBEEF, 1'b1, 32'h0};
      tbl[4]  = '{2'b10, 5'd0,  5'd0,  32'h0,        32'hFFFF,  2'b11, 5'd0,  5'd0,  1'b1, 5'd0,  32'h0,        1'b1, 32'h0,    1'b1, 32'h0};
      tbl[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,     2'b01, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 32'h0,    1'b0, 32'h0};
      tbl[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,     2'b01, 5'd9,  5'd0,  1'b1, 5'd9,  32'h0,        1'b1, 32'h0,    1'b0, 32'h0};
      tbl[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,     2'b11, 5'd9,  5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    1'b0, 32'h200};
      tbl[8]  = '{2'b01, 5'd9,  5'd0,  32'h55,       32'h0,     2'b01, 5'd9,  5'd0,  1'b0, 5'd0,  32'h55,       1'b1, 32'h0,    1'b0, 32'h200};
      tbl[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,     2'b01, 5'd9,  5'd0,  1'b0, 5'd0,  32'h55,       1'b1, 32'h0,    1'b0, 32'h0};
      tbl[10] = '{2'b01, 5'd9,  5'd0,  32'h66,       32'h0,     2'b10, 5'd0,  5'd9,  1'b1, 5'd9,  32'h0,        1'b0, 32'h66,   1'b1, 32'h0};
      tbl[11] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,     2'b01, 5'd9,  5'd0,  1'b0, 5'd0,  32'h66,       1'b0, 32'h0,    1'b0, 32'h200};
      tbl[12] = '{2'b01, 5'd9,  5'd0,  32'h77,       32'h0,     2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    1'b0, 32'h200};

      // Initial reset brings both instances to a known state
      idle();
      rst = 1'b0;
      @(negedge clk);
      tick();
      chk_en = 1'b1;

      // Preload, then a reset cycle that also carries writes and an issue
      idle();
      we = 2'b11; waddr = {5'd4, 5'd3}; wdata = {32'hBBBB0004, 32'hAAAA0003};
      iss_en = 1'b1; iss_addr = 5'd6;
      tick();
      idle();
      rst = 1'b0; we = 2'b11; waddr = {5'd4, 5'd3}; wdata = {32'h44, 32'h33};
      iss_en = 1'b1; iss_addr = 5'd8; re = 2'b11; raddr = {5'd4, 5'd3};
      #1;
      chk("pre_reset_busy6", 64'(q_busy[6]), 64'd1);
      chk("in_reset_rdata", 64'(c_rdata), 64'd0);
      chk("in_reset_rvalid", 64'(c_rvalid), 64'd0);
      tick();
      idle();
      re = 2'b11; raddr = {5'd4, 5'd3};
      #1;
      chk("post_reset_rdata", 64'(c_rdata), 64'd0);
      chk("post_reset_rvalid", 64'(c_rvalid), 64'd3);
      chk("post_reset_busy", 64'(c_busy), 64'd0);
      chk("post_reset_qrdata", 64'(q_rdata), 64'd0);
      chk("post_reset_qrvalid", 64'(q_rvalid), 64'd0);
      tick();

      // Directed vectors: write/read, priority, bypass, x0 and scoreboard
      for (int n = 0; n < 13; n++) begin
         idle();
         we = tbl[n].we; waddr = {tbl[n].wa1, tbl[n].wa0}; wdata = {tbl[n].wd1, tbl[n].wd0};
         re = tbl[n].re; raddr = {tbl[n].ra1, tbl[n].ra0};
         iss_en = tbl[n].iss; iss_addr = tbl[n].ia;
         #1;
         chk($sformatf("vec%0d_rdata0", n), 64'(c_rdata[31:0]), 64'(tbl[n].ed0));
         chk($sformatf("vec%0d_rvalid0", n), 64'(c_rvalid[0]), 64'(tbl[n].ev0));
         chk($sformatf("vec%0d_rdata1", n), 64'(c_rdata[63:32]), 64'(tbl[n].ed1));
         chk($sformatf("vec%0d_rvalid1", n), 64'(c_rvalid[1]), 64'(tbl[n].ev1));
         chk($sformatf("vec%0d_busy", n), 64'(c_busy), 64'(tbl[n].ebusy));
         tick();
      end

      // Registered read with stall while the source register is rewritten
      idle();
      we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h1234};
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd3};
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd3}; stall = 1'b1;
      we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h5678};
      #1;
      chk("stall_first_data", 64'(q_rdata[31:0]), 64'h1234);
      chk("stall_first_valid", 64'(q_rvalid[0]), 64'd1);
      tick();
      idle();
      re = 2'b01; raddr = {5'd0, 5'd3};
      #1;
      chk("stall_hold_data", 64'(q_rdata[31:0]), 64'h1234);
      tick();
      idle();
      #1;
      chk("stall_release_data", 64'(q_rdata[31:0]), 64'h5678);
      chk("stall_release_valid", 64'(q_rvalid[0]), 64'd1);
      tick();

      // Random traffic on a small address range to force collisions
      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 63) != 0);
         stall    = ($urandom_range(0, 3) == 0);
         we       = 2'($urandom);
         waddr    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
         wdata    = {32'($urandom), 32'($urandom)};
         re       = 2'($urandom);
         raddr    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
         iss_en   = 1'($urandom_range(0, 1));
         iss_addr = 5'($urandom_range(0, 15));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
